fxp32s_normalizer: RTL and testbench

FXP32S_NORMALIZER -- requirements
Module: fxp32s_normalizer

---
 rtl/fxp32s_normalizer.sv | 114 +++++++++++
 tb/tb_fxp32s_normalizer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fxp32s_normalizer.sv
// fxp32s_normalizer: normalizes a signed 32-bit fixed-point operand so that
// bits 31 and 30 differ. A fixed 5-step binary search finds the redundant
// sign bits. Each step shifts by 16, 8, 4, 2, then 1. Every operand takes
// the same number of cycles, so latency does not depend on the data.
module fxp32s_normalizer #(
  parameter int LSB_POW = -24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_shift,
  output logic        out_shift_sign,
  output logic [7:0]  out_exp,
  output logic        out_zero,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  // Exponent of bit 30 of the raw operand. Each left shift lowers it by one.
  localparam logic [7:0] EXP_BASE = 8'(30 + LSB_POW);

  state_t      state_reg;
  logic [31:0] work_reg;
  logic [4:0]  count_reg;
  logic [2:0]  stage_reg;

  logic [31:0] work_next;
  logic [4:0]  count_next;

  logic [4:0]  stage_hit;
  logic [31:0] stage_work [5];

  // Per-stage candidates. A stage shifts by W when its top W+1 bits are all
  // equal, because those W bits only repeat the sign.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int W = 16 >> gi;
      assign stage_hit[gi]  = (&work_reg[31:31-W]) | ~(|work_reg[31:31-W]);
      assign stage_work[gi] = work_reg << W;
    end
  endgenerate

  // Select the active stage's result. Keep the current work value when that stage does not apply.
  always_comb begin
    work_next  = work_reg;
    count_next = count_reg;
    for (int k = 0; k < 5; k++) begin
      if (stage_reg == 3'(k) && stage_hit[k]) begin
        work_next  = stage_work[k];
        count_next = count_reg + 5'(16 >> k);
      end
    end
  end

  // Control FSM and registered outputs. Results load on the last search step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      work_reg       <= '0;
      count_reg      <= '0;
      stage_reg      <= '0;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_shift      <= '0;
      out_exp        <= '0;
      out_zero       <= 1'b0;
      out_shift_sign <= 1'b1;
    end else begin
      out_shift_sign <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            work_reg  <= in_data;
            count_reg <= '0;
            stage_reg <= '0;
            in_ready  <= 1'b0;
            state_reg <= SEARCH;
          end
        end
        SEARCH: begin
          work_reg  <= work_next;
          count_reg <= count_next;
          if (stage_reg == 3'd4) begin
            stage_reg <= '0;
            state_reg <= DONE;
            out_valid <= 1'b1;
            out_data  <= work_next;
            out_shift <= {27'b0, count_next};
            out_exp   <= EXP_BASE - {3'b0, count_next};
            out_zero  <= (work_next == 32'h0);
          end else begin
            stage_reg <= stage_reg + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp32s_normalizer.sv
// Directed and random checks for fxp32s_normalizer with the default LSB_POW.
module tb_fxp32s_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [31:0] out_shift;
  logic        out_shift_sign;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_mis = 0;

  fxp32s_normalizer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_shift(out_shift),
    .out_shift_sign(out_shift_sign), .out_exp(out_exp), .out_zero(out_zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Count of redundant sign bits: leading bits equal to bit 31, minus one.
  function automatic int ref_cnt(input logic [31:0] d);
    int n = 0;
    for (int i = 30; i >= 0; i--) begin
      if (d[i] != d[31]) break;
      n++;
    end
    return n;
  endfunction

  // One operand: accept, check latency and results, optionally stall, then drain.
  task automatic run_op(input logic [31:0] d, input logic [31:0] e_data,
                        input logic [31:0] e_shift, input logic [7:0] e_exp,
                        input logic e_zero, input int hold, input bit verbose);
    int lat;
    logic [31:0] rt;
    @(negedge clk);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 32'd5);
    check("out_data", out_data, e_data);
    check("out_shift", out_shift, e_shift);
    check("out_exp", {24'b0, out_exp}, {24'b0, e_exp});
    check("out_zero", {31'b0, out_zero}, {31'b0, e_zero});
    check("shift_sign", {31'b0, out_shift_sign}, 32'd1);
    rt = $signed(out_data) >>> out_shift[4:0];
    check("round_trip", rt, d);
    if (verbose)
      $display("op in=0x%08h data=0x%08h shift=%0d exp=%0d zero=%0b lat=%0d",
               d, out_data, out_shift, $signed(out_exp), out_zero, lat);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      in_data  = ~d;
      in_valid = c[0];
      @(posedge clk); #1;
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_ready", {31'b0, in_ready}, 32'd0);
      check("hold_data", out_data, e_data);
      check("hold_shift", out_shift, e_shift);
    end
    if (hold > 0) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("drain_valid", {31'b0, out_valid}, 32'd0);
    check("drain_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int          cnt;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_shift", out_shift, 32'd0);
    check("rst_out_exp", {24'b0, out_exp}, 32'd0);
    check("rst_out_zero", {31'b0, out_zero}, 32'd0);
    check("rst_shift_sign", {31'b0, out_shift_sign}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h0100_0000, 32'h4000_0000, 32'd6,  8'h00, 1'b0, 0, 1);
    run_op(32'h0000_0001, 32'h4000_0000, 32'd30, 8'hE8, 1'b0, 0, 1);
    run_op(32'hC000_0000, 32'h8000_0000, 32'd1,  8'h05, 1'b0, 0, 1);
    run_op(32'h0000_0000, 32'h0000_0000, 32'd31, 8'hE7, 1'b1, 0, 1);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 32'd31, 8'hE7, 1'b0, 0, 1);
    run_op(32'h4000_0000, 32'h4000_0000, 32'd0,  8'h06, 1'b0, 0, 1);
    run_op(32'h8000_0000, 32'h8000_0000, 32'd0,  8'h06, 1'b0, 0, 1);
    run_op(32'hFFFF_FFFE, 32'h8000_0000, 32'd30, 8'hE8, 1'b0, 0, 1);
    run_op(32'h0000_8000, 32'h4000_0000, 32'd15, 8'hF7, 1'b0, 10, 1);

    // Reset while the search is at stage 2.
    @(negedge clk);
    in_data = 32'h0001_2345; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_data", out_data, 32'd0);
    $display("op mid-search reset: valid=%0b ready=%0b", out_valid, in_ready);
    @(negedge clk);
    rst = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
      check("midrst_quiet", {31'b0, out_valid}, 32'd0);
    end
    run_op(32'hF000_0000, 32'h8000_0000, 32'd3, 8'h03, 1'b0, 0, 1);

    for (int r = 0; r < 10000; r++) begin
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = ~d;
      cnt = ref_cnt(d);
      run_op(d, d << cnt, 32'(cnt), 8'(6 - cnt), d == 32'h0, 0, 0);
    end
    $display("random: 10000 operands issued");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
